// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with frame-synchronous
// double-buffered display value. Optional leading-zero blanking: SEG_LZB_EN.
module seg_scan_ctrl #(
  parameter logic [15:0] CLK_DIV      = 16'd50000,
  parameter logic [15:0] BLANK_CYCLES = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] nibble_sel(input logic [15:0] v, input logic [1:0] i);
    logic [3:0] n;
    case (i)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      2'd3:    n = v[15:12];
      default: n = 4'h0;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] digit_enable(input logic [1:0] i);
    logic [3:0] a;
    case (i)
      2'd0:    a = 4'b1110;
      2'd1:    a = 4'b1101;
      2'd2:    a = 4'b1011;
      2'd3:    a = 4'b0111;
      default: a = 4'b1111;
    endcase
    return a;
  endfunction

`ifdef SEG_LZB_EN
  // A digit is a leading zero when it and every higher digit are zero; digit 0 always shows.
  function automatic logic lead_zero(input logic [15:0] v, input logic [1:0] i);
    logic z;
    case (i)
      2'd3:    z = (v[15:12] == 4'h0);
      2'd2:    z = (v[15:8] == 8'h00);
      2'd1:    z = (v[15:4] == 12'h000);
      default: z = 1'b0;
    endcase
    return z;
  endfunction
`endif

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] act_q, act_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;

  logic        slot_end_s;
  logic        frame_end_s;
  logic        wr_accept_s;
  logic        blank_digit_s;
  phase_e      phase_s;

  // Slot timer: cnt runs 0..CLK_DIV-1, idx steps to the next digit on wrap.
  always_comb begin
    slot_end_s  = (cnt_q == (CLK_DIV - 16'd1));
    frame_end_s = slot_end_s && (idx_q == 2'd3);
    if (slot_end_s) begin
      cnt_d = 16'd0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 16'd1;
      idx_d = idx_q;
    end
  end

  // Double buffer: writes land in pend; pend moves to act only on the frame boundary.
  // Accept requires an empty pend, so it can never coincide with a transfer.
  always_comb begin
    wr_accept_s  = wr_en && !pend_valid_q;
    act_d        = act_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (wr_accept_s) begin
      pend_d       = wr_data;
      pend_valid_d = 1'b1;
    end else if (frame_end_s && pend_valid_q) begin
      act_d        = pend_q;
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end
  end

  // Display decode: blank at the start of each slot, otherwise light digit idx.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    if (cnt_q < BLANK_CYCLES) begin
      phase_s = PH_BLANK;
    end else begin
      phase_s = PH_DRIVE;
    end
`ifdef SEG_LZB_EN
    blank_digit_s = lead_zero(act_q, idx_q);
`else
    blank_digit_s = 1'b0;
`endif
    case (phase_s)
      PH_DRIVE: begin
        if (blank_digit_s) begin
          an_d  = 4'b1111;
          seg_d = 7'b1111111;
        end else begin
          an_d  = digit_enable(idx_q);
          seg_d = hex_to_seg(nibble_sel(act_q, idx_q));
        end
      end
      PH_BLANK: begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
      end
      default: begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
      end
    endcase
  end

  // State and output registers; reset clears everything including any pending value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= 16'd0;
      idx_q        <= 2'd0;
      act_q        <= 16'h0000;
      pend_q       <= 16'h0000;
      pend_valid_q <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_q        <= act_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign wr_ready = ~pend_valid_q;
  assign an       = an_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (CLK_DIV=8, BLANK_CYCLES=2) against a
// cycle-count reference model; follows SEG_LZB_EN when defined.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;
  localparam int CDI  = 8;
  localparam int BCI  = 2;
  localparam int FRM  = 4 * CDI;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = 16'h0000;
  logic        wr_ready;
  logic [3:0]  an;
  logic [6:0]  seg;

  seg_scan_ctrl #(.CLK_DIV(16'd8), .BLANK_CYCLES(16'd2)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .wr_ready(wr_ready), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: n counts cycles since reset release; slot/digit follow by division.
  int          m_n;
  logic [15:0] m_act, m_pend;
  logic        m_pv;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_ready;
  logic [6:0]  hex_tab [16];

  function automatic bit lz_blank(input logic [15:0] v, input int d);
`ifdef SEG_LZB_EN
    return (d > 0) && ((v >> (4 * d)) == 16'h0000);
`else
    return (d < 0) && (v == 16'h0000);
`endif
  endfunction

  task automatic tick();
    int cnt, idx;
    bit bnd, acc;
    logic [3:0] nib;
    @(posedge clk);
    if (!reset) begin
      m_n = 0; m_act = 16'h0; m_pend = 16'h0; m_pv = 1'b0;
      exp_an = 4'b1111; exp_seg = 7'b1111111;
    end else begin
      cnt = m_n % CDI;
      idx = (m_n / CDI) % 4;
      nib = 4'((m_act >> (4 * idx)) & 16'h000F);
      if (cnt >= BCI && !lz_blank(m_act, idx)) begin
        exp_an  = 4'b1111 & ~(4'b0001 << idx);
        exp_seg = hex_tab[nib];
      end else begin
        exp_an  = 4'b1111;
        exp_seg = 7'b1111111;
      end
      bnd = ((m_n % FRM) == FRM - 1);
      acc = wr_en && !m_pv;
      if (bnd && m_pv) begin m_act = m_pend; m_pv = 1'b0; end
      if (acc) begin m_pend = wr_data; m_pv = 1'b1; end
      m_n++;
    end
    exp_ready = !m_pv;
    #1;
  endtask

  task automatic align_to(input int pos);
    for (int i = 0; i < 2 * FRM && (m_n % FRM) != pos; i++) tick();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 3 * FRM && !wr_ready; i++) tick();
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL wait_ready timeout got=%b exp=1", wr_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (an !== 4'b1111) begin failures++; $display("FAIL reset_an got=%b exp=1111", an); end
      checks++; if (seg !== 7'b1111111) begin failures++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
      checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", wr_ready); end
    end
    wr_en = 1'b1; wr_data = 16'h9999;
    tick();
    wr_en = 1'b0;
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_ignore_wr got=%b exp=1", wr_ready); end
    reset = 1'b1;
  endtask

  task automatic test_idle_scan();
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++; if (an !== exp_an) begin failures++; $display("FAIL idle_an n=%0d got=%b exp=%b", m_n, an, exp_an); end
      checks++; if (seg !== exp_seg) begin failures++; $display("FAIL idle_seg n=%0d got=%b exp=%b", m_n, seg, exp_seg); end
      checks++; if (wr_ready !== exp_ready) begin failures++; $display("FAIL idle_ready n=%0d got=%b exp=%b", m_n, wr_ready, exp_ready); end
    end
  endtask

  task automatic test_write_1234();
    align_to(CDI + 1);
    wr_en = 1'b1; wr_data = 16'h1234;
    tick();
    wr_en = 1'b0;
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL w1234_ready_fall got=%b exp=0", wr_ready); end
    for (int i = 0; i < 2 * FRM + 8; i++) begin
      tick();
      checks++; if (an !== exp_an) begin failures++; $display("FAIL w1234_an n=%0d got=%b exp=%b", m_n, an, exp_an); end
      checks++; if (seg !== exp_seg) begin failures++; $display("FAIL w1234_seg n=%0d got=%b exp=%b", m_n, seg, exp_seg); end
      checks++; if (wr_ready !== exp_ready) begin failures++; $display("FAIL w1234_ready n=%0d got=%b exp=%b", m_n, wr_ready, exp_ready); end
    end
  endtask

  task automatic test_back_to_back();
    wait_ready();
    align_to(12);
    wr_en = 1'b1; wr_data = 16'hAAAA;
    tick();
    wr_data = 16'hBBBB;
    tick();
    wr_en = 1'b0;
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL b2b_refused got=%b exp=0", wr_ready); end
    for (int i = 0; i < 3 * FRM && !wr_ready; i++) begin
      tick();
      checks++; if (an !== exp_an) begin failures++; $display("FAIL b2b_an n=%0d got=%b exp=%b", m_n, an, exp_an); end
      checks++; if (seg !== exp_seg) begin failures++; $display("FAIL b2b_seg n=%0d got=%b exp=%b", m_n, seg, exp_seg); end
    end
    wr_en = 1'b1; wr_data = 16'hBBBB;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 2 * FRM + 4; i++) begin
      tick();
      checks++; if (an !== exp_an) begin failures++; $display("FAIL b2b_bb_an n=%0d got=%b exp=%b", m_n, an, exp_an); end
      checks++; if (seg !== exp_seg) begin failures++; $display("FAIL b2b_bb_seg n=%0d got=%b exp=%b", m_n, seg, exp_seg); end
      checks++; if (wr_ready !== exp_ready) begin failures++; $display("FAIL b2b_ready n=%0d got=%b exp=%b", m_n, wr_ready, exp_ready); end
    end
  endtask

  task automatic test_boundary_write();
    wait_ready();
    align_to(FRM - 1);
    wr_en = 1'b1; wr_data = 16'hFFFF;
    tick();
    wr_en = 1'b0;
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL bnd_captured got=%b exp=0", wr_ready); end
    for (int i = 0; i < 2 * FRM + 4; i++) begin
      tick();
      checks++; if (an !== exp_an) begin failures++; $display("FAIL bnd_an n=%0d got=%b exp=%b", m_n, an, exp_an); end
      checks++; if (seg !== exp_seg) begin failures++; $display("FAIL bnd_seg n=%0d got=%b exp=%b", m_n, seg, exp_seg); end
      checks++; if (wr_ready !== exp_ready) begin failures++; $display("FAIL bnd_ready n=%0d got=%b exp=%b", m_n, wr_ready, exp_ready); end
    end
  endtask

  task automatic test_lzb();
    wait_ready();
    wr_en = 1'b1; wr_data = 16'h00A5;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 2 * FRM + 4; i++) begin
      tick();
      checks++; if (an !== exp_an) begin failures++; $display("FAIL lzb_an n=%0d got=%b exp=%b", m_n, an, exp_an); end
      checks++; if (seg !== exp_seg) begin failures++; $display("FAIL lzb_seg n=%0d got=%b exp=%b", m_n, seg, exp_seg); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_data = 16'($urandom);
      if ((i % 97) == 5) wr_data = 16'($urandom_range(0, 255));
      tick();
      checks++; if (an !== exp_an) begin failures++; $display("FAIL rnd_an n=%0d got=%b exp=%b", m_n, an, exp_an); end
      checks++; if (seg !== exp_seg) begin failures++; $display("FAIL rnd_seg n=%0d got=%b exp=%b", m_n, seg, exp_seg); end
      checks++; if (wr_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", m_n, wr_ready, exp_ready); end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    wait_ready();
    align_to(CDI);
    wr_en = 1'b1; wr_data = 16'h5A5A;
    tick();
    wr_en = 1'b0;
    align_to(2 * CDI + 4);
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL rstmid_pending got=%b exp=0", wr_ready); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (an !== 4'b1111) begin failures++; $display("FAIL rstmid_an_async got=%b exp=1111", an); end
    checks++; if (seg !== 7'b1111111) begin failures++; $display("FAIL rstmid_seg_async got=%b exp=1111111", seg); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready_async got=%b exp=1", wr_ready); end
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 2 * FRM + 4; i++) begin
      tick();
      checks++; if (an !== exp_an) begin failures++; $display("FAIL rstmid_an n=%0d got=%b exp=%b", m_n, an, exp_an); end
      checks++; if (seg !== exp_seg) begin failures++; $display("FAIL rstmid_seg n=%0d got=%b exp=%b", m_n, seg, exp_seg); end
      checks++; if (wr_ready !== exp_ready) begin failures++; $display("FAIL rstmid_ready n=%0d got=%b exp=%b", m_n, wr_ready, exp_ready); end
    end
  endtask

  initial begin
    hex_tab[0]  = 7'b1000000; hex_tab[1]  = 7'b1111001; hex_tab[2]  = 7'b0100100; hex_tab[3]  = 7'b0110000;
    hex_tab[4]  = 7'b0011001; hex_tab[5]  = 7'b0010010; hex_tab[6]  = 7'b0000010; hex_tab[7]  = 7'b1111000;
    hex_tab[8]  = 7'b0000000; hex_tab[9]  = 7'b0010000; hex_tab[10] = 7'b0001000; hex_tab[11] = 7'b0000011;
    hex_tab[12] = 7'b1000110; hex_tab[13] = 7'b0100001; hex_tab[14] = 7'b0000110; hex_tab[15] = 7'b0001110;
    m_n = 0; m_act = 16'h0; m_pend = 16'h0; m_pv = 1'b0;
    exp_an = 4'b1111; exp_seg = 7'b1111111; exp_ready = 1'b1;
    test_reset();
    test_idle_scan();
    test_write_1234();
    test_back_to_back();
    test_boundary_write();
    test_lzb();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
